// File: rtl/obi_to_wb_if.sv
// OBI request/response and Wishbone classic bus bundles
// used by the OBI-to-Wishbone bridge.
interface obi_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req_i;
  logic                    gnt_o;
  logic [ADDR_WIDTH-1:0]   addr_i;
  logic                    we_i;
  logic [DATA_WIDTH/8-1:0] be_i;
  logic [DATA_WIDTH-1:0]   wdata_i;
  logic                    rvalid_o;
  logic [DATA_WIDTH-1:0]   rdata_o;
  logic                    err_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    wbm_cyc_o;
  logic                    wbm_stb_o;
  logic                    wbm_we_o;
  logic [DATA_WIDTH/8-1:0] wbm_sel_o;
  logic [ADDR_WIDTH-1:0]   wbm_adr_o;
  logic [DATA_WIDTH-1:0]   wbm_dat_o;
  logic [DATA_WIDTH-1:0]   wbm_dat_i;
  logic                    wbm_ack_i;
  logic                    wbm_err_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o,
    output wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
    input  wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/obi_to_wb.sv
// OBI slave to Wishbone classic master bridge,
// one outstanding transaction, watchdog on hung cycles.
module obi_to_wb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  obi_if.slave obi,
  wb_if.master wb
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [CW-1:0]         cnt_q;
  logic                  take;
  logic                  expire;
  logic                  we_q;
  logic [BW-1:0]         sel_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  // Grant only depends on req and state, never on the WB side.
  assign obi.gnt_o = obi.req_i & (state_q != BUS);
  assign take      = obi.req_i & obi.gnt_o;
  assign expire    = (TIMEOUT_CYCLES != 0) && (cnt_q == TO);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take) state_d = BUS;
      end
      BUS: begin
        if (wb.wbm_ack_i | wb.wbm_err_i | expire)
          state_d = RESP;
      end
      RESP: begin
        state_d = take ? BUS : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (take) begin
        we_q  <= obi.we_i;
        sel_q <= obi.be_i;
        adr_q <= obi.addr_i;
        dat_q <= obi.wdata_i;
      end
      if (state_q == BUS) begin
        if (cnt_q != '1) cnt_q <= cnt_q + CW'(1);
        // err beats ack, ack beats the watchdog
        if (wb.wbm_err_i) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end else if (wb.wbm_ack_i) begin
          err_q   <= 1'b0;
          rdata_q <= we_q ? '0 : wb.wbm_dat_i;
        end else if (expire) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign wb.wbm_cyc_o = (state_q == BUS);
  assign wb.wbm_stb_o = (state_q == BUS);
  assign wb.wbm_we_o  = we_q;
  assign wb.wbm_sel_o = sel_q;
  assign wb.wbm_adr_o = adr_q;
  assign wb.wbm_dat_o = dat_q;

  assign obi.rvalid_o = (state_q == RESP);
  assign obi.rdata_o  = rdata_q;
  assign obi.err_o    = err_q;

endmodule

// File: tb/tb_obi_to_wb.sv
// Scoreboard bench for obi_to_wb with a scripted
// Wishbone slave and a 4-cycle watchdog.
module tb_obi_to_wb;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc_n = 0;
  int   checks = 0;
  int   errors = 0;
  int   nresp  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;

  exp_t sb[$];

  obi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) obi ();
  wb_if  #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb ();

  obi_to_wb #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .obi   (obi),
    .wb    (wb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && obi.rvalid_o) begin
      nresp++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid cycle=%0d actual=1 required=0",
                 cyc_n);
      end else begin
        e = sb.pop_front();
        chk("rdata", obi.rdata_o, e.rdata);
        chk("err", obi.err_o, e.err);
        chk("rvalid_cycle", cyc_n, e.at);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"},
        {wb.wbm_cyc_o, wb.wbm_stb_o, obi.rvalid_o,
         obi.err_o, wb.wbm_we_o}, 0);
    chk({tag, "_rdata"}, obi.rdata_o, 0);
    chk({tag, "_adr"}, wb.wbm_adr_o, 0);
    chk({tag, "_sel"}, wb.wbm_sel_o, 0);
    chk({tag, "_dat"}, wb.wbm_dat_o, 0);
  endtask

  // kind: 0 ack, 1 ack+err, 2 no answer (watchdog)
  task automatic xact(input logic [31:0] addr,
                      input logic        we,
                      input logic [3:0]  be,
                      input logic [31:0] wdata,
                      input int          waits,
                      input int          kind,
                      input logic [31:0] sdata);
    exp_t e;
    e.at    = cyc_n + waits + 2;
    e.err   = (kind != 0);
    e.rdata = (kind != 0 || we) ? 32'h0 : sdata;
    sb.push_back(e);
    obi.req_i   = 1'b1;
    obi.addr_i  = addr;
    obi.we_i    = we;
    obi.be_i    = be;
    obi.wdata_i = wdata;
    @(negedge clk);
    chk("gnt", obi.gnt_o, 1);
    @(posedge clk); #1;
    obi.req_i   = 1'b0;
    obi.addr_i  = ~addr;
    obi.we_i    = ~we;
    obi.be_i    = ~be;
    obi.wdata_i = ~wdata;
    for (int i = 0; i <= waits; i++) begin
      if (i == waits && kind != 2) begin
        wb.wbm_ack_i = 1'b1;
        wb.wbm_err_i = (kind == 1);
        wb.wbm_dat_i = sdata;
      end
      @(negedge clk);
      chk("cyc_stb", {wb.wbm_cyc_o, wb.wbm_stb_o}, 2'b11);
      chk("adr", wb.wbm_adr_o, addr);
      chk("we", wb.wbm_we_o, we);
      chk("sel", wb.wbm_sel_o, be);
      chk("dat_o", wb.wbm_dat_o, wdata);
      @(posedge clk); #1;
      wb.wbm_ack_i = 1'b0;
      wb.wbm_err_i = 1'b0;
    end
    @(negedge clk);
    chk("cyc_drop", {wb.wbm_cyc_o, wb.wbm_stb_o}, 0);
    @(posedge clk); #1;
  endtask

  initial begin : main
    exp_t e;
    int   c0;
    obi.req_i    = 1'b1;
    obi.addr_i   = '0;
    obi.we_i     = 1'b0;
    obi.be_i     = '0;
    obi.wdata_i  = '0;
    wb.wbm_dat_i = '0;
    wb.wbm_ack_i = 1'b0;
    wb.wbm_err_i = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("gnt_in_reset", obi.gnt_o, 1);
    chk_zero("reset");
    obi.req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // zero-wait read
    xact(32'h3000_0010, 1'b0, 4'hF, 32'h0, 0, 0,
         32'hDEAD_BEEF);
    // write with three wait states
    xact(32'h3000_0020, 1'b1, 4'h3, 32'h1234_5678, 3, 0,
         32'hFFFF_FFFF);
    // ack on the same cycle the watchdog expires
    xact(32'h3000_0030, 1'b0, 4'hF, 32'h0, 4, 0,
         32'hCAFE_0001);

    // back-to-back reads with req held high
    c0 = cyc_n;
    e.rdata = 32'h1111_1111; e.err = 1'b0; e.at = c0 + 2;
    sb.push_back(e);
    e.rdata = 32'h2222_2222; e.err = 1'b0; e.at = c0 + 4;
    sb.push_back(e);
    obi.req_i  = 1'b1;
    obi.addr_i = 32'h3000_0100;
    obi.we_i   = 1'b0;
    obi.be_i   = 4'hF;
    @(negedge clk);
    chk("b2b_gnt0", obi.gnt_o, 1);
    @(posedge clk); #1;
    obi.addr_i   = 32'h3000_0104;
    wb.wbm_ack_i = 1'b1;
    wb.wbm_dat_i = 32'h1111_1111;
    @(negedge clk);
    chk("b2b_gnt_bus", obi.gnt_o, 0);
    chk("b2b_cyc1", wb.wbm_cyc_o, 1);
    chk("b2b_adr1", wb.wbm_adr_o, 32'h3000_0100);
    @(posedge clk); #1;
    wb.wbm_ack_i = 1'b0;
    @(negedge clk);
    chk("b2b_gnt_resp", obi.gnt_o, 1);
    chk("b2b_cyc_resp", wb.wbm_cyc_o, 0);
    @(posedge clk); #1;
    obi.req_i    = 1'b0;
    obi.addr_i   = '0;
    wb.wbm_ack_i = 1'b1;
    wb.wbm_dat_i = 32'h2222_2222;
    @(negedge clk);
    chk("b2b_cyc2", wb.wbm_cyc_o, 1);
    chk("b2b_adr2", wb.wbm_adr_o, 32'h3000_0104);
    @(posedge clk); #1;
    wb.wbm_ack_i = 1'b0;
    @(negedge clk);
    chk("b2b_cyc_drop", wb.wbm_cyc_o, 0);
    @(posedge clk); #1;

    // ack and err together
    xact(32'h3000_0040, 1'b0, 4'hF, 32'h0, 1, 1,
         32'h5555_AAAA);
    // hung slave, watchdog fires after 5 bus cycles
    xact(32'h3000_0050, 1'b0, 4'hF, 32'h0, 4, 2,
         32'h0);

    // stray ack while idle
    wb.wbm_ack_i = 1'b1;
    wb.wbm_dat_i = 32'h7777_7777;
    repeat (3) begin
      @(negedge clk);
      chk("stray_cyc", wb.wbm_cyc_o, 0);
      @(posedge clk); #1;
    end
    wb.wbm_ack_i = 1'b0;

    // reset in the middle of a bus cycle
    obi.req_i  = 1'b1;
    obi.addr_i = 32'h3000_0060;
    obi.we_i   = 1'b1;
    obi.be_i   = 4'hC;
    obi.wdata_i = 32'h0BAD_F00D;
    @(posedge clk); #1;
    obi.req_i = 1'b0;
    #2;
    chk("pre_rst_cyc", wb.wbm_cyc_o, 1);
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    xact(32'h3000_0070, 1'b0, 4'hF, 32'h0, 1, 0,
         32'h0123_4567);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    chk("resp_count", nresp, 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obi_to_wb.md
# obi_to_wb

OBI slave to Wishbone classic master bridge: accepts OBI requests from a core-side initiator and replays each one as a single Wishbone classic cycle on the peripheral bus. It is the opposite direction of the existing Wishbone-to-OBI bridge and sits between an OBI initiator (CPU or DMA data port) and Wishbone slaves (caravel-style peripherals). It allows one outstanding transaction and returns exactly one OBI response per grant. A watchdog converts a hung Wishbone cycle into an OBI error response.

## Interface
- ADDR_WIDTH, 32, address width on both sides
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 255, Wishbone cycles to wait for ack/err before aborting; 0 disables the watchdog
- clk_i  in  1  single clock; both sides are synchronous to it
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  1  OBI request
- gnt_o  out  1  OBI grant
- addr_i  in  ADDR_WIDTH  OBI address
- we_i  in  1  OBI write enable
- be_i  in  DATA_WIDTH/8  OBI byte enables
- wdata_i  in  DATA_WIDTH  OBI write data
- rvalid_o  out  1  OBI response valid, exactly one cycle per transaction
- rdata_o  out  DATA_WIDTH  OBI read data; 0 for writes and errors
- err_o  out  1  OBI error, valid with rvalid_o
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe; always equal to wbm_cyc_o
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  DATA_WIDTH/8  Wishbone byte select
- wbm_adr_o  out  ADDR_WIDTH  Wishbone address
- wbm_dat_o  out  DATA_WIDTH  Wishbone write data
- wbm_dat_i  in  DATA_WIDTH  Wishbone read data
- wbm_ack_i  in  1  Wishbone acknowledge
- wbm_err_i  in  1  Wishbone error

## Operation
- FSM states: IDLE, BUS, RESP. Reset state IDLE.
- gnt_o = req_i when state is IDLE or RESP; 0 in BUS. Combinational from req_i, no combinational path from any Wishbone input.
- On req_i && gnt_o: addr_i, we_i, be_i and wdata_i are registered into the Wishbone output registers; the next state is BUS.
- BUS: wbm_cyc_o = wbm_stb_o = 1 with the registered values held constant. The watchdog counter clears on entry and increments each BUS cycle.
- In BUS, wbm_err_i sampled high: latch err=1 and rdata=0. Otherwise wbm_ack_i sampled high: latch err=0, and latch rdata=wbm_dat_i for reads or 0 for writes. Either one moves the state to RESP, and cyc/stb drop on the next edge.
- err has priority when ack and err are sampled together.
- Watchdog: when TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES with no ack/err, latch err=1 and rdata=0, then go to RESP and drop cyc/stb. An ack on the same cycle as expiry wins over the timeout.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. The counter saturates and does not wrap.
- RESP: rvalid_o=1 for exactly one cycle, with rdata_o/err_o from the latches. The next state is BUS if a new request is granted this cycle, otherwise IDLE.
- rdata_o and err_o hold their last values outside rvalid_o. The checker treats them as valid only with rvalid_o.
- wbm_ack_i/wbm_err_i outside BUS are ignored and must not produce a response.
- Wishbone outputs other than cyc/stb keep their last values when idle.
- Reset asserted mid-transaction: all state and outputs clear immediately (asynchronously). cyc/stb drop without waiting for ack, and no response is issued for the aborted transaction.

## Timing
- Reset values: gnt_o follows req_i (state IDLE). All other outputs are 0: rvalid_o, rdata_o, err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o.
- Cycle 0: req_i && gnt_o.
- Cycle 1: cyc/stb high.
- Zero-wait slave: ack in cycle 1, rvalid_o in cycle 2. Each Wishbone wait state adds one cycle.
- Back-to-back: a request granted in the RESP cycle puts cyc/stb high on the following cycle. Peak throughput is one transaction per 2 cycles.
- Timeout: cyc/stb are high for exactly TIMEOUT_CYCLES+1 cycles. rvalid_o (err_o=1) follows on the next cycle.
- OBI address-phase inputs are sampled only at the grant edge. Changes while BUS is active have no effect.

## Test plan
- Read, zero-wait slave: req at cycle 0 with addr 0x3000_0010. Expect:
  - cyc/stb and adr 0x3000_0010 with we=0 at cycle 1.
  - Slave acks at cycle 1 with 0xDEADBEEF.
  - rvalid_o=1, rdata_o=0xDEADBEEF, err_o=0 at cycle 2 only.
- Write, 3 wait states: we=1, be=0x3, wdata 0x1234_5678. Expect:
  - sel=0x3 and dat_o=0x1234_5678 held for 4 cycles.
  - rvalid_o 1 cycle after ack, with rdata_o=0 and err_o=0.
- Back-to-back: req held high for two reads. Expect:
  - gnt_o=0 throughout BUS; second grant in the RESP cycle.
  - cyc/stb for the second read starts the cycle after the first rvalid_o.
  - Two rvalid_o pulses, 2 cycles apart, with correct data each.
- Error paths: a slave asserting ack and err together yields err_o=1, rdata_o=0. With TIMEOUT_CYCLES=4 and no ack, expect:
  - cyc/stb high for 5 cycles.
  - rvalid_o with err_o=1 on the next cycle.
  - A stray ack afterwards produces no response.
- Reset mid-cycle: rst_ni low while cyc/stb is high. Expect:
  - cyc/stb and all outputs 0 immediately, with no clock edge needed.
  - No rvalid_o after release.
  - A new read completes normally.
